vga2axis: RTL and testbench
===========================

// Module: vga2axis
// PURPOSE
//  Converts the VGA-style pixel stream from the HDMI receive path into an AXI-stream video
//  feed for the frame buffer writer. Input: pixel valid, raw H/V sync and 8-bit RGB.
//  Measures the frame geometry and locks to it. Output marks start-of-frame (TUSER) and
//  end-of-line (TLAST). Overflow is absorbed by dropping pixels to the next frame start.
// PARAMETERS
//  LGFIFO  5   log2 output FIFO depth (32 entries of {user,last,rgb})
//  LGDIM   12  width of the x/y counters and of o_width/o_height
// PORTS
//  i_clk          in   1      pixel clock; single clock domain
//  i_reset_n      in   1      reset, asynchronous assert, active low
//  i_pix_valid    in   1      active-video pixel this cycle
//  i_hsync        in   1      raw horizontal sync, any polarity
//  i_vsync        in   1      raw vertical sync, any polarity
//  i_red,i_grn,i_blu in 8     pixel components
//  M_AXIS_TVALID  out  1      output beat valid
//  M_AXIS_TREADY  in   1      downstream ready
//  M_AXIS_TDATA   out  24     {red,grn,blu}
//  M_AXIS_TLAST   out  1      last pixel of a line
//  M_AXIS_TUSER   out  1      first pixel of a frame
//  o_width        out  LGDIM  measured active pixels per line
//  o_height       out  LGDIM  measured active lines per frame
//  o_locked       out  1      geometry locked; pixels being forwarded
//  o_overflow     out  1      1-cycle pulse: FIFO full on a write attempt
// BEHAVIOUR
//  Reset (async, i_reset_n=0): every output is 0, FSM=UNLOCKED, FIFO empty, counters 0.
//  Inputs are registered once. Every other rule uses the registered copies.
//  V polarity: vidle is loaded with vsync on each cycle where pix_valid=1.
//  Frame start (fs) = vsync!=vidle && vsync_prev==vidle. hsync is used for nothing else.
//  Line end = pix_valid 1->0. Counters: x counts valid pixels in the line; y counts line ends.
//  x and y saturate at 2^LGDIM-1. Saturation counts as a mismatch.
//  FSM:
//   UNLOCKED -> MEASURE on fs. Zero x,y.
//   MEASURE: the first line end loads o_width=x. Any later line with x!=o_width -> UNLOCKED.
//    At the next fs: if o_width!=0 && y!=0, load o_height=y and go to LOCKED. Else restart MEASURE.
//   LOCKED: each valid pixel is written to the FIFO with
//    TUSER = (x==0 && y==0) and TLAST = (x==o_width-1).
//    Long line: pix_valid while x==o_width -> UNLOCKED; that pixel is not written.
//    Short line: line end with x!=o_width -> UNLOCKED.
//    At fs with y!=o_height -> UNLOCKED.
//    On UNLOCKED, pixels already queued still drain.
//   DROP (from LOCKED on overflow): no FIFO writes. Mismatch checks still run.
//    At fs -> LOCKED, and the next pixel carries TUSER. o_locked stays 1 in DROP.
//  o_locked = (FSM==LOCKED || FSM==DROP).
//  Overflow: a write with FIFO full asserts o_overflow for 1 cycle, discards the pixel and
//   enters DROP. Downstream then sees a truncated frame, with no TLAST on the partial line.
//  AXI rules: TVALID stays high until TREADY. TDATA/TLAST/TUSER are stable while
//   TVALID && !TREADY. A read and a write in the same cycle with the FIFO full is legal;
//   that write is not an overflow.
//  Latency: pixel on input cycle N -> FIFO write at N+1 -> TVALID at N+2, if FIFO empty and idle.
//  Full throughput: one beat per clock while TREADY=1.
// TESTING
//  1 8x4 frames (runs of 8, 4 lines, one vsync pulse per frame), TREADY=1.
//    Frame 1 is measured with no output. From frame 2: o_width=8, o_height=4, o_locked=1.
//    32 beats per frame; TUSER on beat 0 only; TLAST on beats 7,15,23,31.
//  2 Locked, then one 7-pixel line -> o_locked=0 after the line end. Only earlier pixels
//    are emitted. Relocks after two good frame starts.
//  3 LGFIFO=5, TREADY=0 for 40 cycles mid-frame -> exactly one o_overflow pulse and 32
//    beats held. The rest of that frame is dropped. Next frame starts with TUSER=1.
//    o_locked stays 1.
//  4 TREADY random 50% over 3 frames -> beats in order with no loss or duplication.
//    TDATA is stable during every stall.
//  5 i_reset_n=0 mid-frame while TVALID=1 -> TVALID, o_locked, o_width, o_height go to 0
//    asynchronously. Output resumes only after a new measure frame.
//  6 Repeat test 1 with vsync idle-low and idle-high -> identical output.

Source files
------------

// File: rtl/vga2axis_if.sv
// AXI-stream video bus between the VGA capture block and the frame buffer writer.
// A beat transfers on a rising clock edge where TVALID && TREADY are both 1; once the
// master raises TVALID it holds it, and keeps TDATA/TLAST/TUSER unchanged, until that
// edge. TREADY may change freely and never depends on TVALID on the slave side.
interface vga2axis_if;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic [23:0] M_AXIS_TDATA;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TUSER;

    modport master (
        output M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/vga2axis.sv
// VGA pixel stream to AXI-stream video. Measures the active frame geometry, locks to it,
// and forwards pixels through a small FIFO tagged with start-of-frame (TUSER) and
// end-of-line (TLAST). On FIFO overflow the rest of the frame is dropped.
module vga2axis #(
    parameter int LGFIFO = 5,
    parameter int LGDIM  = 12
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_pix_valid,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic [7:0]       i_red,
    input  logic [7:0]       i_grn,
    input  logic [7:0]       i_blu,
    vga2axis_if.master       m_axis,
    output logic [LGDIM-1:0] o_width,
    output logic [LGDIM-1:0] o_height,
    output logic             o_locked,
    output logic             o_overflow,
    output logic [1:0]       o_dbg_state
);
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        MEASURE  = 2'd1,
        LOCKED   = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam int DEPTH = 1 << LGFIFO;

    // Horizontal sync carries no information here: line ends come from pix_valid.
    logic unused_hsync;
    assign unused_hsync = i_hsync;

    logic             pv_q, pv_prev_q, vs_q, vs_prev_q, vidle_q;
    logic [23:0]      rgb_q;
    logic [LGDIM-1:0] x_q, x_d, y_q, y_d;
    logic [LGDIM-1:0] width_q, width_d, height_q, height_d;
    logic             first_q, first_d, ovf_q, ovf_d;
    state_t           state_q, state_d;
    logic [LGFIFO:0]  wr_ptr_q, rd_ptr_q;
    logic [25:0]      mem [0:DEPTH-1];

    logic fs, line_end, x_max, y_max, x_bad, long_px;
    logic full, empty, rd_en, wr_req, wr_en, wr_user, wr_last;
    logic [25:0] rd_word;

    // Register the raw inputs once, plus the history used for edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pv_q      <= 1'b0;
            pv_prev_q <= 1'b0;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            vidle_q   <= 1'b0;
            rgb_q     <= '0;
        end else begin
            pv_q      <= i_pix_valid;
            pv_prev_q <= pv_q;
            vs_q      <= i_vsync;
            vs_prev_q <= vs_q;
            if (pv_q)
                vidle_q <= vs_q;   // vsync level during active video is its idle level
            rgb_q     <= {i_red, i_grn, i_blu};
        end
    end

    assign fs       = (vs_q != vidle_q) && (vs_prev_q == vidle_q);
    assign line_end = pv_prev_q && !pv_q;
    assign x_max    = &x_q;
    assign y_max    = &y_q;
    assign x_bad    = (x_q != width_q) || x_max;   // a saturated count never matches
    assign long_px  = pv_q && (x_q == width_q);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[LGFIFO] != rd_ptr_q[LGFIFO]) &&
                   (wr_ptr_q[LGFIFO-1:0] == rd_ptr_q[LGFIFO-1:0]);
    assign rd_en = !empty && m_axis.M_AXIS_TREADY;

    // Geometry tracking FSM: counters, lock decisions and FIFO write requests.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        width_d  = width_q;
        height_d = height_q;
        first_d  = first_q;
        wr_req   = 1'b0;
        wr_user  = 1'b0;
        wr_last  = 1'b0;
        ovf_d    = 1'b0;

        if (pv_q && !x_max)
            x_d = x_q + LGDIM'(1);
        if (line_end) begin
            x_d = '0;
            if (!y_max)
                y_d = y_q + LGDIM'(1);
        end
        if (fs) begin
            x_d = '0;
            y_d = '0;
        end

        case (state_q)
            UNLOCKED: begin
                if (fs) begin
                    state_d = MEASURE;
                    first_d = 1'b1;
                end
            end
            MEASURE: begin
                if (fs) begin
                    if (width_q != '0 && y_q != '0 && !y_max) begin
                        height_d = y_q;
                        state_d  = LOCKED;
                    end else begin
                        first_d = 1'b1;   // stay and measure the new frame from scratch
                    end
                end else if (line_end) begin
                    if (first_q) begin
                        width_d = x_q;
                        first_d = 1'b0;
                        if (x_max)
                            state_d = UNLOCKED;
                    end else if (x_bad) begin
                        state_d = UNLOCKED;
                    end
                end
            end
            default: begin   // LOCKED and DROP share all mismatch checks
                if (fs) begin
                    state_d = (y_q != height_q) ? UNLOCKED : LOCKED;
                end else if (long_px) begin
                    state_d = UNLOCKED;
                end else if (line_end && x_bad) begin
                    state_d = UNLOCKED;
                end else if (pv_q && state_q == LOCKED) begin
                    wr_req  = 1'b1;
                    wr_user = (x_q == '0) && (y_q == '0);
                    wr_last = (x_q == width_q - LGDIM'(1));
                    if (full && !rd_en) begin
                        ovf_d   = 1'b1;
                        state_d = DROP;
                    end
                end
            end
        endcase
    end

    // A simultaneous read frees the slot, so a write into a full FIFO is then legal.
    assign wr_en = wr_req && (!full || rd_en);

    // FSM, counter and measured-geometry state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= UNLOCKED;
            x_q      <= '0;
            y_q      <= '0;
            width_q  <= '0;
            height_q <= '0;
            first_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            width_q  <= width_d;
            height_q <= height_d;
            first_q  <= first_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO pointers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written, outputs are masked when empty.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_ptr_q[LGFIFO-1:0]] <= {wr_user, wr_last, rgb_q};
    end

    assign rd_word = mem[rd_ptr_q[LGFIFO-1:0]];

    assign m_axis.M_AXIS_TVALID = !empty;
    assign m_axis.M_AXIS_TUSER  = !empty && rd_word[25];
    assign m_axis.M_AXIS_TLAST  = !empty && rd_word[24];
    assign m_axis.M_AXIS_TDATA  = empty ? 24'd0 : rd_word[23:0];

    assign o_width     = width_q;
    assign o_height    = height_q;
    assign o_locked    = (state_q == LOCKED) || (state_q == DROP);
    assign o_overflow  = ovf_q;
    assign o_dbg_state = state_q;
endmodule

// File: tb/tb_vga2axis.sv
// Directed bench for vga2axis: frame driver, beat scoreboard and stall-stability monitor.
module tb_vga2axis;
  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_pix_valid, i_hsync, i_vsync;
  logic [7:0] i_red, i_grn, i_blu;
  logic [11:0] o_width, o_height;
  logic       o_locked, o_overflow;
  logic [1:0] o_dbg_state;

  vga2axis_if axis ();

  vga2axis #(.LGFIFO(5), .LGDIM(12)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_pix_valid (i_pix_valid),
    .i_hsync     (i_hsync),
    .i_vsync     (i_vsync),
    .i_red       (i_red),
    .i_grn       (i_grn),
    .i_blu       (i_blu),
    .m_axis      (axis.master),
    .o_width     (o_width),
    .o_height    (o_height),
    .o_locked    (o_locked),
    .o_overflow  (o_overflow),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [25:0] exp_q[$];
  bit   sb_on      = 1'b1;
  bit   rnd_ready  = 1'b0;
  int   stall_left = 0;
  int   hblank     = 4;
  int   beat_cnt   = 0;
  int   ovf_cnt    = 0;
  logic vs_idle    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) axis.M_AXIS_TREADY = 1'b1;
    end else if (rnd_ready) begin
      axis.M_AXIS_TREADY = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    i_reset_n   = 1'b0;
    i_pix_valid = 1'b0;
    i_vsync     = vs_idle;
    repeat (3) tick();
    i_reset_n = 1'b1;
    exp_q.delete();
    beat_cnt = 0;
    ovf_cnt  = 0;
  endtask

  // One frame: vsync pulse, vblank, h lines of w pixels. push_n pixels go to the
  // expected queue; short_ln selects a line driven one pixel short; stall holds
  // TREADY low for 40 cycles from the first pixel.
  task automatic drive_frame(input int w, input int h, input int fid, input int push_n,
                             input int short_ln, input bit stall);
    int pushed = 0;
    i_pix_valid = 1'b0;
    i_vsync = ~vs_idle;
    repeat (3) tick();
    i_vsync = vs_idle;
    repeat (4) tick();
    for (int y = 0; y < h; y++) begin
      int len;
      len = (y == short_ln) ? w - 1 : w;
      if (y == 0 && stall) begin
        stall_left = 40;
        axis.M_AXIS_TREADY = 1'b0;
      end
      for (int x = 0; x < len; x++) begin
        i_pix_valid = 1'b1;
        i_red = 8'(fid);
        i_grn = 8'(y);
        i_blu = 8'(x);
        if (pushed < push_n) begin
          exp_q.push_back({(x == 0 && y == 0), (x == w - 1), 8'(fid), 8'(y), 8'(x)});
          pushed++;
        end
        tick();
      end
      i_pix_valid = 1'b0;
      repeat (hblank) tick();
    end
    repeat (2) tick();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run_basic(input logic idle);
    vs_idle = idle;
    do_reset();
    check("rst_tvalid", axis.M_AXIS_TVALID, 0);
    check("rst_locked", o_locked, 0);
    check("rst_width", o_width, 0);
    check("rst_height", o_height, 0);
    check("rst_overflow", o_overflow, 0);
    drive_frame(8, 4, 1, 0, -1, 1'b0);
    check("measure_no_beats", beat_cnt, 0);
    check("measure_unlocked", o_locked, 0);
    drive_frame(8, 4, 2, 32, -1, 1'b0);
    check("width", o_width, 8);
    check("height", o_height, 4);
    check("locked", o_locked, 1);
    drive_frame(8, 4, 3, 32, -1, 1'b0);
    drain();
    check("basic_beats", beat_cnt, 64);
  endtask

  // scoreboard and stall-stability monitor
  logic [25:0] held;
  bit          stalled = 1'b0;
  always @(negedge i_clk) begin
    logic [25:0] cur;
    cur = {axis.M_AXIS_TUSER, axis.M_AXIS_TLAST, axis.M_AXIS_TDATA};
    if (!i_reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", axis.M_AXIS_TVALID, 1);
        check("hold_beat", cur, held);
      end
      if (axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
        beat_cnt++;
        if (sb_on) begin
          if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
          else check("beat", cur, exp_q.pop_front());
        end
      end
      stalled = axis.M_AXIS_TVALID && !axis.M_AXIS_TREADY;
      held = cur;
      if (o_overflow) ovf_cnt++;
    end
  end

  initial begin
    i_hsync = 1'b0;
    i_red = 8'd0;
    i_grn = 8'd0;
    i_blu = 8'd0;
    axis.M_AXIS_TREADY = 1'b1;

    // 8x4 frames, vsync idle low
    run_basic(1'b0);

    // one short line drops lock; relock after a measure frame
    beat_cnt = 0;
    drive_frame(8, 4, 4, 15, 1, 1'b0);
    check("short_unlocked", o_locked, 0);
    drive_frame(8, 4, 5, 0, -1, 1'b0);
    check("remeasure_unlocked", o_locked, 0);
    drive_frame(8, 4, 6, 32, -1, 1'b0);
    drain();
    check("relock", o_locked, 1);
    check("short_beats", beat_cnt, 47);

    // overflow: 40x3 frames, 40-cycle stall at the start of a locked frame
    do_reset();
    drive_frame(40, 3, 10, 0, -1, 1'b0);
    drive_frame(40, 3, 11, 120, -1, 1'b0);
    drain();
    check("wide_width", o_width, 40);
    check("wide_beats", beat_cnt, 120);
    drive_frame(40, 3, 12, 32, -1, 1'b1);
    check("ovf_pulses", ovf_cnt, 1);
    check("drop_locked", o_locked, 1);
    drive_frame(40, 3, 13, 120, -1, 1'b0);
    drain();
    check("ovf_total_beats", beat_cnt, 272);
    check("ovf_pulses_after", ovf_cnt, 1);
    check("relock_after_drop", o_locked, 1);

    // random backpressure over three frames
    hblank = 16;
    do_reset();
    drive_frame(8, 4, 20, 0, -1, 1'b0);
    rnd_ready = 1'b1;
    drive_frame(8, 4, 21, 32, -1, 1'b0);
    drive_frame(8, 4, 22, 32, -1, 1'b0);
    drive_frame(8, 4, 23, 32, -1, 1'b0);
    drain();
    rnd_ready = 1'b0;
    axis.M_AXIS_TREADY = 1'b1;
    check("rand_beats", beat_cnt, 96);
    check("rand_no_ovf", ovf_cnt, 0);

    // asynchronous reset mid-frame with TVALID high
    hblank = 4;
    sb_on = 1'b0;
    i_vsync = ~vs_idle;
    repeat (3) tick();
    i_vsync = vs_idle;
    repeat (4) tick();
    axis.M_AXIS_TREADY = 1'b0;
    for (int x = 0; x < 8; x++) begin
      i_pix_valid = 1'b1;
      i_blu = 8'(x);
      tick();
    end
    i_pix_valid = 1'b0;
    tick();
    check("pre_reset_tvalid", axis.M_AXIS_TVALID, 1);
    #2 i_reset_n = 1'b0;
    #1;
    check("arst_tvalid", axis.M_AXIS_TVALID, 0);
    check("arst_locked", o_locked, 0);
    check("arst_width", o_width, 0);
    check("arst_height", o_height, 0);
    tick();
    i_reset_n = 1'b1;
    axis.M_AXIS_TREADY = 1'b1;
    exp_q.delete();
    beat_cnt = 0;
    sb_on = 1'b1;
    drive_frame(8, 4, 30, 0, -1, 1'b0);
    check("post_rst_no_beats", beat_cnt, 0);
    drive_frame(8, 4, 31, 32, -1, 1'b0);
    drain();
    check("post_rst_beats", beat_cnt, 32);

    // same 8x4 sequence with vsync idle high
    run_basic(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
